// File: rtl/gate_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_pkg
// Brief    : Shared constants, gate bit indices and FSM encoding for the
//            two-input gate sweep checker.
// Revision : 1.0
// ============================================================================
package gate_sweep_pkg;

    localparam int N_COMBO   = 4;
    localparam int N_GATE    = 6;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NAND = 2;
    localparam int GATE_NOR  = 3;
    localparam int GATE_XOR  = 4;
    localparam int GATE_XNOR = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    function automatic logic [2:0] popcount6(input logic [N_GATE-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < N_GATE; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module   : gate_ref_model
// Brief    : Combinational reference for the six two-input gate outputs.
// Revision : 1.0
// ============================================================================
module gate_ref_model
    import gate_sweep_pkg::*;
(
    input  logic              i_a,
    input  logic              i_b,
    output logic [N_GATE-1:0] o_expected
);

    always_comb begin
        o_expected            = '0;
        o_expected[GATE_AND]  = i_a & i_b;
        o_expected[GATE_OR]   = i_a | i_b;
        o_expected[GATE_NAND] = ~(i_a & i_b);
        o_expected[GATE_NOR]  = ~(i_a | i_b);
        o_expected[GATE_XOR]  = i_a ^ i_b;
        o_expected[GATE_XNOR] = ~(i_a ^ i_b);
    end

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_checker
// Brief    : Drives all four {a,b} combinations into a two-input gate stage,
//            samples its six outputs at the end of each hold and scores them.
// Revision : 1.0
// ============================================================================
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [5:0]       gates,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [5:0]       fail_mask,
    output logic [3:0]       fail_vec
);

    localparam int              CNT_W      = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam int              SUM_W      = ERR_W + 3;

    sweep_state_t      r_state;
    sweep_state_t      w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_idx;
    logic              r_a;
    logic              r_b;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err_count;
    logic [5:0]        r_fail_mask;
    logic [3:0]        r_fail_vec;

    logic              w_sample;
    logic              w_last;
    logic [5:0]        w_expected;
    logic [5:0]        w_mism;
    logic [SUM_W-1:0]  w_err_sum;
    logic [ERR_W-1:0]  w_err_next;

    gate_ref_model u_ref (
        .i_a        (r_idx[1]),
        .i_b        (r_idx[0]),
        .o_expected (w_expected)
    );

    assign w_sample = (r_state == ST_DRIVE) && (r_cnt == C_CNT_LAST);
    assign w_last   = w_sample && (r_idx == 2'd3);
    assign w_mism   = gates ^ w_expected;

    // Sum is three bits wider than the counter so one sample can never wrap it.
    assign w_err_sum  = SUM_W'(r_err_count) + SUM_W'(popcount6(w_mism));
    assign w_err_next = (|w_err_sum[SUM_W-1:ERR_W]) ? {ERR_W{1'b1}}
                                                     : w_err_sum[ERR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_next = ST_DRIVE;
            ST_DRIVE: if (w_last) w_state_next = ST_DONE;
            ST_DONE:              w_state_next = ST_IDLE;
            default:              w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_mask <= '0;
            r_fail_vec  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt       <= '0;
                        r_idx       <= '0;
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= '0;
                        r_fail_mask <= '0;
                        r_fail_vec  <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (w_sample) begin
                        r_cnt              <= '0;
                        r_idx              <= r_idx + 2'd1;
                        r_err_count        <= w_err_next;
                        r_fail_mask        <= r_fail_mask | w_mism;
                        r_fail_vec[r_idx]  <= r_fail_vec[r_idx] | (|w_mism);
                        // Inputs move only on hold boundaries; park at 00 for DONE.
                        {r_a, r_b}         <= w_last ? 2'b00 : (r_idx + 2'd1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_pass <= (r_err_count == '0);
                end
                default: ;
            endcase
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_mask = r_fail_mask;
    assign fail_vec  = r_fail_vec;

endmodule
`default_nettype wire
